// File: rtl/jt900h_intc.sv
// Edge-latching interrupt controller for the jt900h CPU: programmable 3-bit
// levels per source plus NMI, registered arbitration, and a vector latch on acknowledge.
module jt900h_intc #(
    parameter int         NSRC   = 16,
    parameter logic [7:0] VBASE  = 8'h20,
    parameter logic [7:0] NMIVEC = 8'h08
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [NSRC-1:0] src,
    input  logic            nmi,
    input  logic [2:0]      addr,
    input  logic [7:0]      din,
    input  logic            we,
    output logic [7:0]      dout,
    output logic            irq,
    output logic [2:0]      int_lvl,
    input  logic            irq_ack,
    output logic [7:0]      vec
);

    localparam int SW = (NSRC > 2) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] pend, src_l, pend_set, pend_wclr, pend_aclr;
    logic [2:0]      prio [NSRC];
    logic            nmi_pend, nmi_l, ack_l, sel_nmi, ack_rise;
    logic [SW-1:0]   sel, arb_sel;
    logic            arb_req, arb_nmi;
    logic [2:0]      arb_lvl;

    assign pend_set = src & ~src_l;
    assign ack_rise = irq_ack & ~ack_l & irq;

    always_comb begin
        pend_wclr = '0;
        pend_aclr = '0;
        for (int i = 0; i < NSRC; i++) begin
            pend_wclr[i] = we && (addr == 3'(i / 2)) && !din[4 * (i % 2) + 3];
            pend_aclr[i] = ack_rise && !sel_nmi && (sel == SW'(i));
        end
    end

    // Strict compare in ascending order keeps the lowest index on ties;
    // starting from level 0 masks prio=0 sources.
    always_comb begin
        arb_req = 1'b0;
        arb_nmi = 1'b0;
        arb_lvl = 3'd0;
        arb_sel = '0;
        if (nmi_pend) begin
            arb_req = 1'b1;
            arb_nmi = 1'b1;
            arb_lvl = 3'd7;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (pend[i] && prio[i] > arb_lvl) begin
                    arb_req = 1'b1;
                    arb_lvl = prio[i];
                    arb_sel = SW'(i);
                end
            end
        end
    end

    always_comb begin
        dout = 8'd0;
        for (int k = 0; k < NSRC / 2; k++) begin
            if (addr == 3'(k))
                dout = {pend[2*k+1], prio[2*k+1], pend[2*k], prio[2*k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            nmi_pend <= 1'b0;
            src_l    <= src;
            nmi_l    <= nmi;
            ack_l    <= irq_ack;
            irq      <= 1'b0;
            int_lvl  <= 3'd0;
            sel      <= '0;
            sel_nmi  <= 1'b0;
            vec      <= 8'd0;
            for (int i = 0; i < NSRC; i++)
                prio[i] <= 3'd0;
        end else if (cen) begin
            src_l    <= src;
            nmi_l    <= nmi;
            ack_l    <= irq_ack;
            // A new edge wins over any clear in the same cycle.
            pend     <= (pend & ~pend_wclr & ~pend_aclr) | pend_set;
            nmi_pend <= (nmi_pend & ~(ack_rise & sel_nmi)) | (nmi & ~nmi_l);
            for (int i = 0; i < NSRC; i++) begin
                if (we && addr == 3'(i / 2))
                    prio[i] <= din[4 * (i % 2) +: 3];
            end
            if (!irq_ack) begin
                irq     <= arb_req;
                int_lvl <= arb_lvl;
                sel     <= arb_sel;
                sel_nmi <= arb_nmi;
            end
            if (ack_rise)
                vec <= sel_nmi ? NMIVEC : VBASE + 8'({sel, 2'b00});
        end
    end

endmodule
